// File: rtl/score_pkg.sv
// Shared types and constants for the dodge-game score keeper.
package score_pkg;

    typedef enum logic [1:0] {IDLE, RUN, OVER} game_state_t;
    typedef logic [3:0] bcd_digit_t;

    localparam logic [7:0] BCD_MAX  = 8'h99;
    localparam logic [7:0] BCD_ZERO = 8'h00;

    function automatic logic is_bcd(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Control inputs and display/status outputs of the score keeper.
interface score_keeper_if;

    logic       start;
    logic       point;
    logic       collide;
    logic       show_hi;
    logic [7:0] score_out;
    logic       running;
    logic       game_over;

    modport master (
        output start, point, collide, show_hi,
        input  score_out, running, game_over
    );

    modport slave (
        input  start, point, collide, show_hi,
        output score_out, running, game_over
    );

endinterface

// File: rtl/bcd_add_digit.sv
// One BCD digit adder: a + b + cin with decimal carry-out.
module bcd_add_digit
    import score_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);

    logic [4:0] raw;

    // Largest raw sum is 9 + 9 + 1 = 19, so a single -10 correction suffices.
    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (raw > 5'd9) begin
            sum  = bcd_digit_t'(raw - 5'd10);
            cout = 1'b1;
        end else begin
            sum  = raw[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Two-digit BCD score counter and game-state FSM for the dodge game.
// Optional high-score register enabled by defining SCORE_HIGH_EN.
module score_keeper
    import score_pkg::*;
#(
    parameter bit          SATURATE = 1'b1,
    parameter int unsigned STEP     = 1
) (
    input logic           clk,
    input logic           reset,
    score_keeper_if.slave bus
);

    localparam bcd_digit_t STEP_D = bcd_digit_t'(STEP);

    game_state_t state, next_state;
    logic [7:0]  score, score_next;

    logic start_s, start_q, point_s, point_q, col_s, col_q;
    logic start_ev, point_ev, col_ev;

    bcd_digit_t units_sum, tens_sum;
    logic       units_cout, tens_cout;

    // Inputs are registered once, then compared against their previous sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_s <= 1'b0;
            start_q <= 1'b0;
            point_s <= 1'b0;
            point_q <= 1'b0;
            col_s   <= 1'b0;
            col_q   <= 1'b0;
        end else begin
            start_s <= bus.start;
            start_q <= start_s;
            point_s <= bus.point;
            point_q <= point_s;
            col_s   <= bus.collide;
            col_q   <= col_s;
        end
    end

    assign start_ev = start_s & ~start_q;
    assign point_ev = point_s & ~point_q;
    assign col_ev   = col_s   & ~col_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            score <= BCD_ZERO;
        end else begin
            state <= next_state;
            score <= score_next;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_ev) next_state = RUN;
            RUN:     if (col_ev)   next_state = OVER;
            OVER:    if (start_ev) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.running   = (state == RUN);
        bus.game_over = (state == OVER);
    end

    bcd_add_digit u_units (
        .a    (score[3:0]),
        .b    (STEP_D),
        .cin  (1'b0),
        .sum  (units_sum),
        .cout (units_cout)
    );

    bcd_add_digit u_tens (
        .a    (score[7:4]),
        .b    (4'd0),
        .cin  (units_cout),
        .sum  (tens_sum),
        .cout (tens_cout)
    );

    // A tens carry-out means the sum reached 100; the dropped carry is the wrap.
    always_comb begin
        score_next = score;
        case (state)
            IDLE, OVER: begin
                if (start_ev) score_next = BCD_ZERO;
            end
            RUN: begin
                if (point_ev && !col_ev) begin
                    if (tens_cout && SATURATE) score_next = BCD_MAX;
                    else                       score_next = {tens_sum, units_sum};
                end
            end
            default: score_next = BCD_ZERO;
        endcase
    end

`ifdef SCORE_HIGH_EN
    logic [7:0] hi_score, hi_next, out_r;

    // Packed BCD orders the same as its decimal value, so a plain compare works.
    always_comb begin
        hi_next = hi_score;
        if (state == RUN && col_ev && score > hi_score) hi_next = score;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_score <= BCD_ZERO;
            out_r    <= BCD_ZERO;
        end else begin
            hi_score <= hi_next;
            out_r    <= bus.show_hi ? hi_next : score_next;
        end
    end

    assign bus.score_out = out_r;
`else
    logic unused_show_hi;

    assign unused_show_hi = bus.show_hi;
    assign bus.score_out  = score;
`endif

    a_score_bcd: assert property (@(posedge clk) disable iff (reset) is_bcd(score));

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: saturating and wrapping instances against a decimal model.
module tb_score_keeper;

    localparam int STEP = 1;

    logic clk = 1'b0;
    logic reset;

    score_keeper_if bus_sat ();
    score_keeper_if bus_wrap ();

    score_keeper #(.SATURATE(1'b1), .STEP(STEP)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_sat.slave)
    );

    score_keeper #(.SATURATE(1'b0), .STEP(STEP)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_wrap.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state per instance: 0 = sat, 1 = wrap; game 0 idle, 1 run, 2 over.
    int         m_game [2];
    int         m_score[2];
    logic [7:0] exp_out[2];
`ifdef SCORE_HIGH_EN
    int         m_hi   [2];
`endif
    logic s_s, s_q, p_s, p_q, c_s, c_q;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic pt, input logic co, input logic sh);
        @(posedge clk);
        #2;
        bus_sat.start    = st;
        bus_sat.point    = pt;
        bus_sat.collide  = co;
        bus_sat.show_hi  = sh;
        bus_wrap.start   = st;
        bus_wrap.point   = pt;
        bus_wrap.collide = co;
        bus_wrap.show_hi = sh;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, bus_sat.show_hi);
    endtask

    task automatic pulseStart();
        applyStimulus(1'b1, 1'b0, 1'b0, bus_sat.show_hi);
        idle(1);
    endtask

    task automatic pulseCollide();
        applyStimulus(1'b0, 1'b0, 1'b1, bus_sat.show_hi);
        idle(1);
    endtask

    task automatic points(input int n);
        repeat (n) begin
            applyStimulus(1'b0, 1'b1, 1'b0, bus_sat.show_hi);
            idle(1);
        end
    endtask

    task automatic modelStep();
        logic ev_s, ev_p, ev_c;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_game[k]  = 0;
                m_score[k] = 0;
                exp_out[k] = 8'h00;
`ifdef SCORE_HIGH_EN
                m_hi[k]    = 0;
`endif
            end
            {s_s, s_q, p_s, p_q, c_s, c_q} = '0;
        end else begin
            ev_s = s_s & ~s_q;
            ev_p = p_s & ~p_q;
            ev_c = c_s & ~c_q;
            for (int k = 0; k < 2; k++) begin
                if (m_game[k] == 1) begin
                    if (ev_c) begin
                        m_game[k] = 2;
`ifdef SCORE_HIGH_EN
                        if (m_score[k] > m_hi[k]) m_hi[k] = m_score[k];
`endif
                    end else if (ev_p) begin
                        m_score[k] = m_score[k] + STEP;
                        if (m_score[k] > 99) m_score[k] = (k == 0) ? 99 : m_score[k] - 100;
                    end
                end else if (ev_s) begin
                    m_game[k]  = 1;
                    m_score[k] = 0;
                end
`ifdef SCORE_HIGH_EN
                exp_out[k] = bus_sat.show_hi ? to_bcd(m_hi[k]) : to_bcd(m_score[k]);
`else
                exp_out[k] = to_bcd(m_score[k]);
`endif
            end
            s_q = s_s; s_s = bus_sat.start;
            p_q = p_s; p_s = bus_sat.point;
            c_q = c_s; c_s = bus_sat.collide;
        end
    endtask

    task automatic compareAll();
        checkOutput("sat_score",   bus_sat.score_out,        exp_out[0]);
        checkOutput("sat_running", 8'(bus_sat.running),      8'(m_game[0] == 1));
        checkOutput("sat_over",    8'(bus_sat.game_over),    8'(m_game[0] == 2));
        checkOutput("sat_bcd",     8'(bus_sat.score_out[3:0] <= 4'd9 && bus_sat.score_out[7:4] <= 4'd9), 8'd1);
        checkOutput("wrap_score",  bus_wrap.score_out,       exp_out[1]);
        checkOutput("wrap_running", 8'(bus_wrap.running),    8'(m_game[1] == 1));
        checkOutput("wrap_over",   8'(bus_wrap.game_over),   8'(m_game[1] == 2));
        checkOutput("wrap_bcd",    8'(bus_wrap.score_out[3:0] <= 4'd9 && bus_wrap.score_out[7:4] <= 4'd9), 8'd1);
    endtask

    initial begin
        reset = 1'b1;
        bus_sat.start  = 0; bus_sat.point  = 0; bus_sat.collide  = 0; bus_sat.show_hi  = 0;
        bus_wrap.start = 0; bus_wrap.point = 0; bus_wrap.collide = 0; bus_wrap.show_hi = 0;

        fork
            forever begin
                @(posedge clk or posedge reset);
                modelStep();
            end
            forever begin
                @(negedge clk);
                if (!reset) compareAll();
            end
            begin
                #2_000_000;
                $display("[TB] FAIL watchdog timeout");
                $fatal(1, "[TB] watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        checkOutput("rst_score",   bus_sat.score_out,     8'h00);
        checkOutput("rst_running", 8'(bus_sat.running),   8'h00);
        checkOutput("rst_over",    8'(bus_sat.game_over), 8'h00);

        // Start, then check the first point's two-cycle latency.
        pulseStart();
        idle(2);
        checkOutput("start_running", 8'(bus_sat.running), 8'h01);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("lat_1clk", bus_sat.score_out, 8'h00);
        @(posedge clk); #1;
        checkOutput("lat_2clk", bus_sat.score_out, 8'h01);
        idle(1);
        points(11);
        idle(3);
        checkOutput("twelve_pts", bus_sat.score_out, 8'h12);

        // Held point level counts once.
        pulseCollide();
        pulseStart();
        idle(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        idle(3);
        checkOutput("held_point", bus_sat.score_out, 8'h01);

        // 101 points: saturate vs wrap.
        pulseCollide();
        pulseStart();
        idle(2);
        points(101);
        idle(3);
        checkOutput("sat_101",  bus_sat.score_out,  8'h99);
        checkOutput("wrap_101", bus_wrap.score_out, 8'h01);

        // Simultaneous point and collide at 07.
        pulseCollide();
        pulseStart();
        idle(2);
        points(7);
        idle(2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);
        checkOutput("pc_over",  8'(bus_sat.game_over), 8'h01);
        checkOutput("pc_score", bus_sat.score_out,     8'h07);
        points(1);
        idle(3);
        checkOutput("over_hold", bus_sat.score_out, 8'h07);
        pulseStart();
        idle(3);
        checkOutput("restart_run",   8'(bus_sat.running), 8'h01);
        checkOutput("restart_score", bus_sat.score_out,   8'h00);

        // Asynchronous reset in the middle of a count at 23.
        points(23);
        idle(2);
        checkOutput("pre_rst_23", bus_sat.score_out, 8'h23);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checkOutput("async_score",   bus_sat.score_out,     8'h00);
        checkOutput("async_running", 8'(bus_sat.running),   8'h00);
        checkOutput("async_over",    8'(bus_sat.game_over), 8'h00);
        @(posedge clk);
        #2 reset = 1'b0;

`ifdef SCORE_HIGH_EN
        pulseStart();
        idle(2);
        points(15);
        idle(2);
        pulseCollide();
        pulseStart();
        idle(2);
        points(9);
        idle(2);
        pulseCollide();
        idle(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        checkOutput("hi_shown", bus_sat.score_out, 8'h15);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        checkOutput("hi_last", bus_sat.score_out, 8'h09);
`endif

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Upstream feeder for the two-digit HEX display decoder in the dodge game. It counts dodged obstacles as a two-digit packed BCD score, 00 to 99, and tracks the game state (idle / running / over). Its registered 8-bit `score_out` drives the display decoder's address input directly: upper nibble is the tens digit, lower nibble is the units digit.

Parameters:
- SATURATE, 1, 1 = hold at 99 on overflow; 0 = wrap 99 -> 00.
- STEP, 1, BCD units added per point event. Legal values 1-9.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level from debounced key; a rising edge begins or restarts a game.
- point  input  1  level/pulse from obstacle logic; each rising edge scores once.
- collide  input  1  level/pulse; a rising edge ends the game.
- show_hi  input  1  selects the high score onto `score_out`; only used with SCORE_HIGH_EN.
- score_out  output  8  packed BCD {tens, units}, registered.
- running  output  1  high in the RUN state.
- game_over  output  1  high in the OVER state.

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - score = 8'h00; score_out = 8'h00.
  - running = 0; game_over = 0.
  - Edge-detect flops cleared to 0.
- Edge detection: start, point and collide are each registered once. An event is `sig & ~sig_q`. A held level produces exactly one event.
- FSM:
  - IDLE: on a start event, go to RUN and clear score to 00. All other inputs are ignored.
  - RUN: a point event adds STEP in BCD.
    - Units digit > 9 after the add: subtract 10 and carry into tens.
    - Tens > 9 after the carry: with SATURATE=1 the score becomes 99; with SATURATE=0 the score becomes (sum - 100) in BCD.
    - A collide event goes to OVER; the score is frozen.
  - OVER: the score holds. A start event goes to RUN and clears score to 00.
- Simultaneous events:
  - collide and point in the same cycle in RUN: collide wins, no increment.
  - start in RUN: ignored.
  - start and collide in the same cycle in RUN: collide wins.
- Latency: `score_out`, running and game_over change on the clock edge after the input edge is sampled. That is 2 clk cycles from the input rising to the output change (1 cycle edge-detect + 1 cycle state/score register).
- The score never holds a non-BCD nibble. The implementation must assert this.
- Reset mid-game forces IDLE immediately, asynchronously. Pending edges are discarded.

Optional Feature:
Macro SCORE_HIGH_EN.
- Defined:
  - Adds an 8-bit BCD hi_score register, reset to 00.
  - On the RUN->OVER transition, if score > hi_score (compared as packed BCD), hi_score takes score in the same cycle.
  - A new game does not clear hi_score.
  - When show_hi = 1, `score_out` = hi_score (registered, 1-cycle latency); otherwise `score_out` = score.
- Not defined: no hi_score register; show_hi is ignored; `score_out` is always score.

Decomposition:
- Package score_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, OVER} game_state_t.
  - typedef logic [3:0] bcd_digit_t.
  - Constants BCD_MAX = 8'h99 and BCD_ZERO = 8'h00.
- One sub-module, bcd_add_digit: combinational. Inputs are a digit, an addend 0-9 and carry-in; outputs are the sum digit and carry-out. Instantiated twice (units, tens).

Test Plan:
1. Assert reset mid-count (score 8'h23) -> score_out = 8'h00, running = 0 and game_over = 0 immediately, without a clock edge.
2. Start edge, then 12 single-cycle point pulses -> score_out = 8'h12. The first update appears exactly 2 clk after the first point rise.
3. point held high for 20 cycles in RUN -> score_out increments once only, 00 -> 01.
4. SATURATE=1: 101 point events -> score_out = 8'h99. SATURATE=0: 101 events -> 8'h01. Nibbles are never > 9 throughout.
5. point and collide rise in the same cycle at score 8'h07 -> game_over = 1, score_out stays 8'h07. A further point gives no change. A start edge gives running = 1 and score_out = 8'h00.
6. SCORE_HIGH_EN: game 1 ends at 8'h15 and game 2 ends at 8'h09 -> with show_hi = 1, score_out = 8'h15. With show_hi = 0, score_out = 8'h09.
